// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings and the transmit FSM state type.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    // Parity bit for a payload whose bits XOR to data_xor.
    function automatic logic parity_bit(input logic data_xor, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is visible on dout without a pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A push against a full buffer is dropped even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Flags come from the occupancy count so wrapped pointers never alias full with empty.
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (!do_push && do_pop) begin
                level <= level - 1'b1;
            end
        end
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: queues words in a FIFO and frames them LSB first on one line.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 40,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned INVERT       = 0,
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] txIn,
    output logic                 txOut,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic [LW-1:0]        level,
    output logic                 overflow
);

    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    tx_state_e            state;
    logic [BW-1:0]        baud;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par;
    logic                 line;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 bit_end;
    logic                 frame_end;
    logic                 load;

    assign push      = send && !rst;
    assign bit_end   = (baud == BAUD_LAST);
    assign frame_end = (state == StStop) && bit_end && (bit_cnt == STOP_LAST);
    // Pop from idle, or straight out of the last stop cycle so frames run back to back.
    assign load      = !empty && ((state == StIdle) || frame_end);

    assign busy  = (state != StIdle);
    assign txOut = line ^ (INVERT != 0);

    sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock(clock),
        .rst  (rst),
        .push (push),
        .pop  (load),
        .din  (txIn),
        .dout (head),
        .full (full),
        .empty(empty),
        .level(level)
    );

    // Sticky drop flag for writes made while the buffer is full.
    always_ff @(posedge clock) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (send && full) begin
            overflow <= 1'b1;
        end
    end

    // Framing FSM; the word and its parity are latched at pop time so later writes cannot disturb it.
    always_ff @(posedge clock) begin
        if (rst) begin
            state   <= StIdle;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            line    <= 1'b1;
        end else begin
            baud <= baud + 1'b1;
            unique case (state)
                StIdle: begin
                    baud <= '0;
                    if (load) begin
                        state <= StStart;
                        shreg <= head;
                        par   <= parity_bit(^head, PARITY);
                        line  <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        state   <= StData;
                        line    <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != PARITY_NONE) begin
                                state <= StParity;
                                line  <= par;
                            end else begin
                                state <= StStop;
                                line  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            line    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        state   <= StStop;
                        line    <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_cnt != STOP_LAST) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (load) begin
                            bit_cnt <= '0;
                            state   <= StStart;
                            shreg   <= head;
                            par     <= parity_bit(^head, PARITY);
                            line    <= 1'b0;
                        end else begin
                            bit_cnt <= '0;
                            state   <= StIdle;
                            line    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    line  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 40, clock cycles per serial bit (16 MHz / 400 kbaud); legal range 2 and above.
REQ-002 Parameter DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 and 2.
REQ-005 Parameter FIFO_DEPTH, default 16, entries in the transmit buffer; power of two, 2 and above.
REQ-006 Parameter INVERT, default 0; when 1, txOut is the logical inverse of the line, for inverted-line protocols such as F.Port/SBUS.
REQ-007 clock  input  1  sole clock; all logic is on its rising edge.
REQ-008 rst  input  1  synchronous reset, active-high.
REQ-009 send  input  1  write strobe; txIn is queued on any clock edge where send=1.
REQ-010 txIn  input  DATA_BITS  byte to queue.
REQ-011 txOut  output  1  serial line.
REQ-012 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-013 empty  output  1  FIFO holds 0 entries.
REQ-014 busy  output  1  a frame is on the line (any state other than IDLE).
REQ-015 level  output  clog2(FIFO_DEPTH+1)  current FIFO occupancy.
REQ-016 overflow  output  1  sticky flag, set when a write is dropped.

Function
REQ-017 Frame format, LSB first: start bit 0, DATA_BITS data bits, optional parity bit, then STOP_BITS stop bits of 1; idle line is 1 (before INVERT is applied).
REQ-018 Each bit holds for exactly CLKS_PER_BIT cycles, timed by a baud counter that restarts at each bit boundary.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP; the transitions are IDLE->START, START->DATA, DATA->PARITY (PARITY!=0) or DATA->STOP, PARITY->STOP, STOP->START when FIFO is non-empty, else STOP->IDLE.
REQ-020 In IDLE with the FIFO non-empty, the FSM pops the head entry and enters START on the same edge.
REQ-021 Latency: a byte written at edge k into an empty FIFO while the FSM is IDLE drives the start bit on txOut from edge k+1.
REQ-022 Back-to-back frames: the next start bit follows the last stop bit cycle with zero idle cycles.
REQ-023 Parity: odd mode makes the XOR of data bits and parity bit equal 1; even mode makes it 0.
REQ-024 A write with full=1 is dropped and sets overflow, even if a pop occurs on the same edge.
REQ-025 A simultaneous write and pop with full=0 leaves level unchanged and preserves order.
REQ-026 Read and write pointers wrap modulo FIFO_DEPTH; full and empty derive from level, never from pointer equality alone.
REQ-027 The shifted byte is captured at pop time; FIFO writes during a frame do not alter it.

Reset
REQ-028 While rst=1 on an edge: FSM goes to IDLE, FIFO is flushed (level=0, empty=1, full=0), overflow=0, baud and bit counters are 0, and txOut is the idle level (1 XOR INVERT).
REQ-029 Reset mid-frame aborts the frame immediately, with no stop bit completion; send is ignored on any edge where rst=1.

Structure
REQ-030 Shared package uart_pkg holds the parity-mode constants (PARITY_NONE/ODD/EVEN) and the FSM state typedef, for reuse by uart_rx successors.
REQ-031 One sub-module, sync_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, level), holds the buffer; framing logic stays in uart_tx_fifo.

Verification
REQ-032 CLKS_PER_BIT=4, 8N1: write 0xA5 once -> txOut low for 4 cycles starting at edge k+1, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high; busy deasserts after 40 cycles.
REQ-033 Even parity, write 0x07 -> parity bit 1; odd parity, same byte -> parity bit 0; STOP_BITS=2 -> line high for 8 cycles before IDLE.
REQ-034 FIFO_DEPTH=4: write 6 bytes on consecutive edges while the line is idle -> the first is popped at once; of the remaining writes, the one made with full=1 is dropped; overflow=1; the line shows 5 frames back-to-back with no idle gap, in the order written.
REQ-035 Assert rst at bit 3 of a frame with 3 bytes queued -> txOut idle on the next edge, level=0, overflow=0; a subsequent write of 0x3C transmits correctly.
REQ-036 INVERT=1 -> txOut is low when idle and every bit is the complement of the INVERT=0 waveform; loopback through uart_rx (CLKS_PER_BIT=40) with an inverter recovers 256 random bytes without error.
